// File: rtl/uart_ci_bridge.sv
// Custom-instruction to UART bridge: sends a command byte plus payload bytes, then
// collects a multi-byte response with a per-byte timeout, whole-frame retry and error report.
module uart_ci_bridge #(
    parameter int unsigned TX_BYTES       = 1,
    parameter int unsigned RX_BYTES       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned MAX_RETRIES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    input  logic        tx_busy,
    input  logic        rdy,
    input  logic [7:0]  rxdata,
    output logic [7:0]  txdata,
    output logic        wr_en,
    output logic        rdy_clr,
    output logic [31:0] result,
    output logic        done,
    output logic        error,
    output logic [4:0]  state
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [4:0] {
        IDLE      = 5'd0,
        SEND      = 5'd1,
        TX_GAP    = 5'd2,
        TX_WAIT   = 5'd3,
        WAIT_DATA = 5'd4,
        CLEAR     = 5'd5,
        DONE      = 5'd6,
        ERROR     = 5'd7
    } state_t;

    state_t        cur, nxt;
    logic [2:0]    idx, idx_n;
    logic [1:0]    rx_idx, rx_idx_n;
    logic [TW-1:0] tmo, tmo_n;
    logic [3:0]    retry, retry_n;
    logic [31:0]   dataa_q, dataa_n;
    logic [7:0]    cmd_q, cmd_n;
    logic [7:0]    txdata_n;
    logic          wr_en_n, rdy_clr_n, done_n, error_n;
    logic [31:0]   result_n;
    logic [7:0]    frame_byte;
    logic          unused_cmd_bits;

    // Only the low byte of datab carries the command.
    assign unused_cmd_bits = ^datab[31:8];
    assign state = cur;

    always_comb begin
        case (idx)
            3'd0:    frame_byte = cmd_q;
            3'd1:    frame_byte = dataa_q[7:0];
            3'd2:    frame_byte = dataa_q[15:8];
            3'd3:    frame_byte = dataa_q[23:16];
            3'd4:    frame_byte = dataa_q[31:24];
            default: frame_byte = 8'h00;
        endcase
    end

    always_comb begin
        nxt       = cur;
        idx_n     = idx;
        rx_idx_n  = rx_idx;
        tmo_n     = tmo;
        retry_n   = retry;
        dataa_n   = dataa_q;
        cmd_n     = cmd_q;
        txdata_n  = txdata;
        wr_en_n   = 1'b0;
        rdy_clr_n = 1'b0;
        done_n    = 1'b0;
        error_n   = 1'b0;
        result_n  = result;
        case (cur)
            IDLE: begin
                if (start) begin
                    dataa_n = dataa;
                    cmd_n   = datab[7:0];
                    retry_n = '0;
                    idx_n   = '0;
                    nxt     = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    wr_en_n  = 1'b1;
                    txdata_n = frame_byte;
                    nxt      = TX_GAP;
                end
            end
            TX_GAP: nxt = TX_WAIT;
            TX_WAIT: begin
                if (!tx_busy) begin
                    if (idx != 3'(TX_BYTES)) begin
                        idx_n = idx + 3'd1;
                        nxt   = SEND;
                    end else begin
                        rx_idx_n = '0;
                        result_n = '0;
                        tmo_n    = '0;
                        nxt      = WAIT_DATA;
                    end
                end
            end
            // A byte arriving on the terminal-count cycle still beats the timeout.
            WAIT_DATA: begin
                if (rdy) begin
                    result_n[{rx_idx, 3'b000} +: 8] = rxdata;
                    rdy_clr_n = 1'b1;
                    nxt       = CLEAR;
                end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                    if (retry < 4'(MAX_RETRIES)) begin
                        retry_n  = retry + 4'd1;
                        result_n = '0;
                        idx_n    = '0;
                        nxt      = SEND;
                    end else begin
                        result_n = '1;
                        done_n   = 1'b1;
                        error_n  = 1'b1;
                        nxt      = ERROR;
                    end
                end else begin
                    tmo_n = tmo + TW'(1);
                end
            end
            CLEAR: begin
                tmo_n = '0;
                if (rx_idx != 2'(RX_BYTES - 1)) begin
                    rx_idx_n = rx_idx + 2'd1;
                    nxt      = WAIT_DATA;
                end else begin
                    done_n = 1'b1;
                    nxt    = DONE;
                end
            end
            DONE:    nxt = IDLE;
            ERROR:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur     <= IDLE;
            idx     <= '0;
            rx_idx  <= '0;
            tmo     <= '0;
            retry   <= '0;
            dataa_q <= '0;
            cmd_q   <= '0;
            txdata  <= '0;
            wr_en   <= 1'b0;
            rdy_clr <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            result  <= '0;
        end else begin
            cur     <= nxt;
            idx     <= idx_n;
            rx_idx  <= rx_idx_n;
            tmo     <= tmo_n;
            retry   <= retry_n;
            dataa_q <= dataa_n;
            cmd_q   <= cmd_n;
            txdata  <= txdata_n;
            wr_en   <= wr_en_n;
            rdy_clr <= rdy_clr_n;
            done    <= done_n;
            error   <= error_n;
            result  <= result_n;
        end
    end

endmodule

// File: tb/tb_uart_ci_bridge.sv
// Directed bench for uart_ci_bridge: a 1/1-byte instance with a short timeout and a
// 4/4-byte instance share the stimulus; each test task checks one instance.
`timescale 1ns/1ps
module tb_uart_ci_bridge;

    logic        clk = 1'b0;
    logic        reset, start, tx_busy, rdy;
    logic [31:0] dataa, datab;
    logic [7:0]  rxdata;

    logic [7:0]  a_txdata, b_txdata;
    logic        a_wr_en, b_wr_en, a_rdy_clr, b_rdy_clr, a_done, b_done, a_error, b_error;
    logic [31:0] a_result, b_result;
    logic [4:0]  a_state, b_state;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] a_tx_q[$];
    logic [7:0] b_tx_q[$];
    logic [4:0] a_states[$];
    int a_clr_cnt = 0;
    int b_clr_cnt = 0;
    int a_done_cnt = 0;

    always #5 clk = ~clk;

    uart_ci_bridge #(.TX_BYTES(1), .RX_BYTES(1), .TIMEOUT_CYCLES(8), .MAX_RETRIES(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .dataa(dataa), .datab(datab),
        .tx_busy(tx_busy), .rdy(rdy), .rxdata(rxdata), .txdata(a_txdata), .wr_en(a_wr_en),
        .rdy_clr(a_rdy_clr), .result(a_result), .done(a_done), .error(a_error), .state(a_state)
    );

    uart_ci_bridge #(.TX_BYTES(4), .RX_BYTES(4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .dataa(dataa), .datab(datab),
        .tx_busy(tx_busy), .rdy(rdy), .rxdata(rxdata), .txdata(b_txdata), .wr_en(b_wr_en),
        .rdy_clr(b_rdy_clr), .result(b_result), .done(b_done), .error(b_error), .state(b_state)
    );

    // Passive monitor: logs transmitted bytes, strobes and state changes mid-cycle.
    always @(negedge clk) begin
        if (a_wr_en) a_tx_q.push_back(a_txdata);
        if (b_wr_en) b_tx_q.push_back(b_txdata);
        if (a_rdy_clr) a_clr_cnt++;
        if (b_rdy_clr) b_clr_cnt++;
        if (a_done) a_done_cnt++;
        if (a_states.size() == 0 || a_states[$] != a_state) a_states.push_back(a_state);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; tx_busy = 1'b0; rdy = 1'b0;
        rxdata = 8'h00; dataa = 32'h0; datab = 32'h0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; tx_busy = 1'b0; rdy = 1'b0;
        rxdata = 8'h00; dataa = 32'h0; datab = 32'h0;
        repeat (2) tick();
        tests_run++; if (a_state !== 5'd0) begin tests_failed++; $display("[TB] FAIL reset_state: got %0d expected 0", a_state); end
        tests_run++; if (a_wr_en !== 1'b0 || a_rdy_clr !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_strobes: got wr_en=%b rdy_clr=%b expected 0 0", a_wr_en, a_rdy_clr); end
        tests_run++; if (a_done !== 1'b0 || a_error !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got done=%b error=%b expected 0 0", a_done, a_error); end
        tests_run++; if (a_result !== 32'h0 || a_txdata !== 8'h0) begin tests_failed++; $display("[TB] FAIL reset_data: got result=%h txdata=%h expected 0 0", a_result, a_txdata); end
        tests_run++; if (b_state !== 5'd0 || b_result !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_b: got state=%0d result=%h expected 0 0", b_state, b_result); end
        reset = 1'b0;
        tick();
        tests_run++; if (a_state !== 5'd0) begin tests_failed++; $display("[TB] FAIL idle_after_reset: got %0d expected 0", a_state); end
    endtask

    task automatic test_basic();
        int bt, bs, bc, wr_seen, done_at;
        logic got, err, match;
        logic [31:0] res;
        logic [4:0] exp_st [10];
        exp_st = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd0};
        do_reset();
        bt = a_tx_q.size(); bs = a_states.size(); bc = a_clr_cnt;
        wr_seen = 0; done_at = 0; got = 1'b0; err = 1'b0; res = 32'h0;
        datab = 32'h05; dataa = 32'h61; start = 1'b1;
        for (int n = 1; n <= 60 && !got; n++) begin
            tick();
            start = 1'b0;
            if (a_wr_en) wr_seen++;
            if (a_rdy_clr) rdy = 1'b0;
            else if (wr_seen == 2 && a_state == 5'd2) begin rdy = 1'b1; rxdata = 8'h41; end
            if (a_done) begin got = 1'b1; done_at = n; res = a_result; err = a_error; end
        end
        tests_run++; if (!got) begin tests_failed++; $display("[TB] FAIL basic_done: got no done expected done within 60 cycles"); end
        tests_run++; if (done_at != 1 + 3 * 2 + 2) begin tests_failed++; $display("[TB] FAIL basic_latency: got %0d expected %0d", done_at, 1 + 3 * 2 + 2); end
        tests_run++; if (res !== 32'h41 || err !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_result: got %h err=%b expected 00000041 err=0", res, err); end
        tick();
        tests_run++; if (a_state !== 5'd0 || a_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_idle: got state=%0d done=%b expected 0 0", a_state, a_done); end
        tick();
        tests_run++;
        if (a_tx_q.size() - bt != 2) begin tests_failed++; $display("[TB] FAIL basic_tx_count: got %0d expected 2", a_tx_q.size() - bt); end
        else if (a_tx_q[bt] !== 8'h05 || a_tx_q[bt+1] !== 8'h61) begin tests_failed++; $display("[TB] FAIL basic_tx_bytes: got %h %h expected 05 61", a_tx_q[bt], a_tx_q[bt+1]); end
        tests_run++; if (a_clr_cnt - bc != 1) begin tests_failed++; $display("[TB] FAIL basic_rdy_clr: got %0d pulses expected 1", a_clr_cnt - bc); end
        match = (a_states.size() - bs == 10);
        if (match) for (int i = 0; i < 10; i++) if (a_states[bs+i] !== exp_st[i]) match = 1'b0;
        tests_run++; if (!match) begin tests_failed++; $display("[TB] FAIL basic_states: got %0d entries expected sequence 1,2,3,1,2,3,4,5,6,0", a_states.size() - bs); end
    endtask

    task automatic test_busy();
        int wr_early;
        do_reset();
        wr_early = 0;
        tx_busy = 1'b1; datab = 32'h05; dataa = 32'h61; start = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            start = 1'b0;
            if (a_wr_en) wr_early++;
            if (n == 10) tx_busy = 1'b0;
        end
        tests_run++; if (wr_early != 0) begin tests_failed++; $display("[TB] FAIL busy_hold: got %0d wr_en pulses expected 0", wr_early); end
        tests_run++; if (a_state !== 5'd1) begin tests_failed++; $display("[TB] FAIL busy_state: got %0d expected 1", a_state); end
        tick();
        tests_run++; if (a_wr_en !== 1'b1 || a_txdata !== 8'h05) begin tests_failed++; $display("[TB] FAIL busy_release: got wr_en=%b txdata=%h expected 1 05", a_wr_en, a_txdata); end
    endtask

    task automatic test_wide();
        int bt, bc, wr_seen, r;
        logic got, err;
        logic [31:0] res, reply;
        logic [39:0] sent;
        do_reset();
        bt = b_tx_q.size(); bc = b_clr_cnt;
        wr_seen = 0; r = 0; got = 1'b0; err = 1'b0; res = 32'h0; reply = 32'h44332211;
        datab = 32'h05; dataa = 32'hDDCCBBAA; start = 1'b1;
        for (int n = 1; n <= 200 && !got; n++) begin
            tick();
            start = 1'b0;
            if (b_wr_en) wr_seen++;
            if (b_rdy_clr) begin rdy = 1'b0; r++; end
            else if (wr_seen >= 5 && !rdy && r < 4) begin rdy = 1'b1; rxdata = reply[8*r +: 8]; end
            if (b_done) begin got = 1'b1; res = b_result; err = b_error; end
        end
        tick();
        tests_run++; if (!got) begin tests_failed++; $display("[TB] FAIL wide_done: got no done expected done within 200 cycles"); end
        sent = '0;
        if (b_tx_q.size() - bt == 5) sent = {b_tx_q[bt+4], b_tx_q[bt+3], b_tx_q[bt+2], b_tx_q[bt+1], b_tx_q[bt]};
        tests_run++; if (sent !== 40'hDDCCBBAA05) begin tests_failed++; $display("[TB] FAIL wide_tx_order: got %h (count %0d) expected DDCCBBAA05", sent, b_tx_q.size() - bt); end
        tests_run++; if (b_clr_cnt - bc != 4) begin tests_failed++; $display("[TB] FAIL wide_rdy_clr: got %0d pulses expected 4", b_clr_cnt - bc); end
        tests_run++; if (res !== 32'h44332211 || err !== 1'b0) begin tests_failed++; $display("[TB] FAIL wide_result: got %h err=%b expected 44332211 err=0", res, err); end
    endtask

    task automatic test_retry();
        int bt, wr_seen, wait_cnt;
        logic got, err, replied;
        logic [31:0] res, sent;
        do_reset();
        bt = a_tx_q.size();
        wr_seen = 0; wait_cnt = 0; got = 1'b0; err = 1'b0; replied = 1'b0; res = 32'h0;
        datab = 32'h05; dataa = 32'h61; start = 1'b1;
        for (int n = 1; n <= 200 && !got; n++) begin
            tick();
            start = 1'b0;
            if (a_wr_en) wr_seen++;
            if (wr_seen == 2 && a_state == 5'd4) wait_cnt++;
            if (a_rdy_clr) rdy = 1'b0;
            else if (wr_seen >= 4 && !replied) begin rdy = 1'b1; rxdata = 8'h7E; replied = 1'b1; end
            if (a_done) begin got = 1'b1; res = a_result; err = a_error; end
        end
        tick();
        tests_run++; if (wait_cnt != 8) begin tests_failed++; $display("[TB] FAIL retry_timeout: got %0d wait cycles expected 8", wait_cnt); end
        sent = '0;
        if (a_tx_q.size() - bt == 4) sent = {a_tx_q[bt+3], a_tx_q[bt+2], a_tx_q[bt+1], a_tx_q[bt]};
        tests_run++; if (sent !== 32'h61056105) begin tests_failed++; $display("[TB] FAIL retry_frames: got %h (count %0d) expected 61056105", sent, a_tx_q.size() - bt); end
        tests_run++; if (!got || res !== 32'h7E || err !== 1'b0) begin tests_failed++; $display("[TB] FAIL retry_result: got done=%b %h err=%b expected 1 0000007e 0", got, res, err); end
    endtask

    task automatic test_error();
        int bt;
        logic got, err;
        logic [31:0] res;
        do_reset();
        bt = a_tx_q.size();
        got = 1'b0; err = 1'b0; res = 32'h0;
        datab = 32'h05; dataa = 32'h61; start = 1'b1;
        for (int n = 1; n <= 200 && !got; n++) begin
            tick();
            start = 1'b0;
            if (a_done) begin got = 1'b1; res = a_result; err = a_error; end
        end
        tests_run++; if (!got) begin tests_failed++; $display("[TB] FAIL error_done: got no done expected done within 200 cycles"); end
        tests_run++; if (err !== 1'b1 || res !== 32'hFFFF_FFFF) begin tests_failed++; $display("[TB] FAIL error_result: got err=%b %h expected 1 ffffffff", err, res); end
        tick();
        tests_run++; if (a_state !== 5'd0 || a_error !== 1'b0 || a_done !== 1'b0) begin tests_failed++; $display("[TB] FAIL error_after: got state=%0d error=%b done=%b expected 0 0 0", a_state, a_error, a_done); end
        tests_run++; if (a_tx_q.size() - bt != 4) begin tests_failed++; $display("[TB] FAIL error_frames: got %0d bytes expected 4", a_tx_q.size() - bt); end
    endtask

    task automatic test_reset_mid();
        int bd;
        logic reached;
        do_reset();
        bd = a_done_cnt; reached = 1'b0;
        datab = 32'h05; dataa = 32'h61; start = 1'b1;
        for (int n = 1; n <= 40 && !reached; n++) begin
            tick();
            start = 1'b0;
            if (a_state == 5'd4) reached = 1'b1;
        end
        tests_run++; if (!reached) begin tests_failed++; $display("[TB] FAIL mid_reach: got state %0d expected 4 within 40 cycles", a_state); end
        #2 reset = 1'b1;
        #1;
        tests_run++; if (a_state !== 5'd0 || a_txdata !== 8'h00 || a_result !== 32'h0) begin tests_failed++; $display("[TB] FAIL mid_async: got state=%0d txdata=%h result=%h expected 0 00 0", a_state, a_txdata, a_result); end
        tests_run++; if (a_wr_en !== 1'b0 || a_rdy_clr !== 1'b0 || a_done !== 1'b0 || a_error !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_strobes: got %b%b%b%b expected 0000", a_wr_en, a_rdy_clr, a_done, a_error); end
        tick();
        reset = 1'b0;
        repeat (20) tick();
        tests_run++; if (a_done_cnt != bd) begin tests_failed++; $display("[TB] FAIL mid_no_done: got %0d done pulses expected 0", a_done_cnt - bd); end
    endtask

    task automatic test_start_ignored();
        int bt, bd, wr_seen;
        logic got, replied;
        logic [31:0] res;
        logic [15:0] sent;
        do_reset();
        bt = a_tx_q.size(); bd = a_done_cnt;
        wr_seen = 0; got = 1'b0; replied = 1'b0; res = 32'h0;
        tx_busy = 1'b1; datab = 32'h05; dataa = 32'h61; start = 1'b1;
        tick();
        start = 1'b0;
        dataa = 32'h99; datab = 32'h77; start = 1'b1;
        tick();
        start = 1'b0; dataa = 32'h0; datab = 32'h0;
        tests_run++; if (a_state !== 5'd1) begin tests_failed++; $display("[TB] FAIL ign_state: got %0d expected 1", a_state); end
        tx_busy = 1'b0;
        for (int n = 1; n <= 60 && !got; n++) begin
            tick();
            if (a_wr_en) wr_seen++;
            if (a_rdy_clr) rdy = 1'b0;
            else if (wr_seen == 2 && !replied) begin rdy = 1'b1; rxdata = 8'h55; replied = 1'b1; end
            if (a_done) begin got = 1'b1; res = a_result; end
        end
        repeat (3) tick();
        sent = '0;
        if (a_tx_q.size() - bt == 2) sent = {a_tx_q[bt+1], a_tx_q[bt]};
        tests_run++; if (sent !== 16'h6105) begin tests_failed++; $display("[TB] FAIL ign_payload: got %h (count %0d) expected 6105", sent, a_tx_q.size() - bt); end
        tests_run++; if (!got || res !== 32'h55) begin tests_failed++; $display("[TB] FAIL ign_result: got done=%b %h expected 1 00000055", got, res); end
        tests_run++; if (a_done_cnt - bd != 1) begin tests_failed++; $display("[TB] FAIL ign_done_count: got %0d expected 1", a_done_cnt - bd); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy();
        test_wide();
        test_retry();
        test_error();
        test_reset_mid();
        test_start_ignored();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
